// File: rtl/main_mem_arbiter_pkg.sv
// Shared types for the two-master MainMem arbiter.
// Build option: MAIN_MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention.
package main_mem_arbiter_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef enum logic [1:0] {
    MEM_SIZE_8  = 2'd0,
    MEM_SIZE_16 = 2'd1,
    MEM_SIZE_32 = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } StArb;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        typ;
    logic [1:0]  size;
  } PortIn_MainMemArbiter;

  typedef struct packed {
    logic [31:0] rdata;
    logic        stall;
  } PortOut_MainMemArbiter;

  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

`ifdef MAIN_MEM_ARB_ROUND_ROBIN_EN
  localparam bit ARB_RR_EN = 1'b1;
`else
  localparam bit ARB_RR_EN = 1'b0;
`endif

endpackage

// File: rtl/main_mem_arb_picker.sv
// Combinational owner selection for the MainMem arbiter.
// Contention policy follows ARB_RR_EN (MAIN_MEM_ARB_ROUND_ROBIN_EN).
module main_mem_arb_picker
  import main_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       owner_o,
  output logic       any_o
);

  logic rr_both;

  assign rr_both = ARB_RR_EN & (&req_i);
  assign any_o   = |req_i;

  always_comb begin
    owner_o = 1'b0;
    unique case (1'b1)
      rr_both:
        owner_o = ~last_grant_i;
      (req_i[0] & ~rr_both):
        owner_o = 1'b0;
      default:
        owner_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares one MainMem port between the CPU (port 0) and a second master.
// Latches the granted request, issues it, and aborts hung accesses.
module main_mem_arbiter
  import main_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 rq_req,
  input  logic [1:0][ADDR_WIDTH-1:0] rq_addr,
  input  logic [1:0][DATA_WIDTH-1:0] rq_wdata,
  input  logic [1:0]                 rq_type,
  input  logic [1:0][1:0]            rq_size,
  output logic [1:0][DATA_WIDTH-1:0] rq_rdata,
  output logic [1:0]                 rq_wait,
  output logic                       mem_req,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic                       mem_type,
  output logic [1:0]                 mem_size,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_wait,
  output logic                       err_timeout
);

  localparam logic [7:0] CNT_LAST =
    8'(TIMEOUT_CYCLES - 1);

  StArb                       state_q;
  logic                       owner_q;
  logic                       last_grant_q;
  logic                       mem_req_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
  logic                       type_q;
  logic [1:0]                 size_q;
  logic [7:0]                 cnt_q;
  logic [7:0]                 cnt_d;
  logic                       err_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_d;

  logic                  pick;
  logic                  any_req;
  logic                  in_wait;
  logic                  ok;
  logic                  abort;
  logic                  fin;
  logic [1:0]            done;
  logic [DATA_WIDTH-1:0] ret_data;

  main_mem_arb_picker u_picker (
    .req_i        (rq_req),
    .last_grant_i (last_grant_q),
    .owner_o      (pick),
    .any_o        (any_req)
  );

  assign in_wait = (state_q == WAIT);
  assign ok      = in_wait & ~mem_wait;
  assign abort   = in_wait & mem_wait
                 & (cnt_q == CNT_LAST);
  assign fin     = ok | abort;
  assign done    = {owner_q, ~owner_q}
                 & {2{fin}};
  assign cnt_d   = cnt_q + 8'd1;

  assign ret_data = ok ? mem_rdata
                  : DATA_WIDTH'(ARB_TIMEOUT_DATA);

  // Completion data is visible in the done cycle and held afterwards.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rdata_d[n] = done[n] ? ret_data
                 : rdata_q[n];
    end
  end

  assign rq_wait     = rq_req & ~done;
  assign rq_rdata    = rdata_d;
  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_type    = type_q;
  assign mem_size    = size_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      type_q       <= 1'b0;
      size_q       <= 2'd0;
      cnt_q        <= 8'd0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rdata_q <= rdata_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q   <= pick;
            addr_q    <= rq_addr[pick];
            wdata_q   <= rq_wdata[pick];
            type_q    <= rq_type[pick];
            size_q    <= rq_size[pick];
            cnt_q     <= 8'd0;
            mem_req_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          mem_req_q <= 1'b0;
          state_q   <= WAIT;
        end
        WAIT: begin
          mem_req_q <= 1'b0;
          if (!mem_wait) begin
            last_grant_q <= owner_q;
            state_q      <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter with a transaction-level model.
// Directed scenarios first, then randomized traffic and memory latency.
module tb_main_mem_arbiter;

  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rq_req;
  logic [1:0][31:0] rq_addr;
  logic [1:0][31:0] rq_wdata;
  logic [1:0]       rq_type;
  logic [1:0][1:0]  rq_size;
  logic [1:0][31:0] rq_rdata;
  logic [1:0]       rq_wait;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_type;
  logic [1:0]       mem_size;
  logic [31:0]      mem_rdata;
  logic             mem_wait;
  logic             err_timeout;

  main_mem_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rq_req      (rq_req),
    .rq_addr     (rq_addr),
    .rq_wdata    (rq_wdata),
    .rq_type     (rq_type),
    .rq_size     (rq_size),
    .rq_rdata    (rq_rdata),
    .rq_wait     (rq_wait),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_type    (mem_type),
    .mem_size    (mem_size),
    .mem_rdata   (mem_rdata),
    .mem_wait    (mem_wait),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        mreq;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        typ;
    logic [1:0]  size;
    logic [1:0]  wt;
    logic [31:0] rd0;
    logic [31:0] rd1;
    bit          kn0;
    bit          kn1;
    logic        err;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   checks   = 0;
  int   failures = 0;

  // staged stimulus, applied at the start of each cycle
  logic        s_rst;
  logic [1:0]  s_req;
  logic [31:0] s_addr  [2];
  logic [31:0] s_wdata [2];
  logic        s_type  [2];
  logic [1:0]  s_size  [2];

  // memory responder
  int          force_k  = -1;
  int          mcnt     = 0;
  logic [31:0] maddr    = '0;
  bit          mem_seen = 1'b0;
  logic [31:0] mem_seen_addr = '0;

  // transaction-level reference state
  int          cyc_n = 0;
  bit          act   = 1'b0;
  int          g     = 0;
  bit          own   = 1'b0;
  logic [31:0] l_addr  = '0;
  logic [31:0] l_wdata = '0;
  logic        l_type  = 1'b0;
  logic [1:0]  l_size  = '0;
  bit          lastg = 1'b1;
  bit          errm  = 1'b0;
  logic [31:0] hold  [2];
  bit          known [2];
  bit          m_done[2];

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return a ^ 32'h1234_5778;
  endfunction

  function automatic int draw_k();
    int r = $urandom_range(0, 9);
    return (r < 6) ? (r % 3) : (r - 3);
  endfunction

  function automatic bit pick(input logic [1:0] r);
`ifdef MAIN_MEM_ARB_ROUND_ROBIN_EN
    if (r == 2'b11) return !lastg;
`endif
    return r[0] ? 1'b0 : 1'b1;
  endfunction

  task automatic cyc();
    exp_t        e;
    bit          dn;
    bit          ok;
    logic [31:0] val;
    @(negedge clk);
    rst    = s_rst;
    rq_req = s_req;
    for (int n = 0; n < 2; n++) begin
      rq_addr[n]  = s_addr[n];
      rq_wdata[n] = s_wdata[n];
      rq_type[n]  = s_type[n];
      rq_size[n]  = s_size[n];
    end
    if (mem_seen) begin
      mcnt  = (force_k >= 0) ? force_k : draw_k();
      maddr = mem_seen_addr;
    end
    mem_wait  = (mcnt > 0);
    mem_rdata = rdf(maddr);
    if (mcnt > 0) mcnt--;
    mem_seen      = (mem_req === 1'b1);
    mem_seen_addr = mem_addr;

    dn  = act && (cyc_n >= g + 2) &&
          (!mem_wait || (cyc_n - g - 2 == TO - 1));
    ok  = dn && !mem_wait;
    val = ok ? rdf(l_addr) : 32'hDEAD_BEEF;
    for (int n = 0; n < 2; n++)
      m_done[n] = dn && (own == n[0]);
    e.cyc   = cyc_n;
    e.mreq  = act && (cyc_n == g + 1);
    e.addr  = l_addr;
    e.wdata = l_wdata;
    e.typ   = l_type;
    e.size  = l_size;
    e.err   = errm;
    e.wt    = s_req & ~{m_done[1], m_done[0]};
    e.rd0   = m_done[0] ? val : hold[0];
    e.rd1   = m_done[1] ? val : hold[1];
    e.kn0   = m_done[0] ? !(ok && l_type) : known[0];
    e.kn1   = m_done[1] ? !(ok && l_type) : known[1];
    if (cyc_n >= 1) expq.push_back(e);

    if (s_rst) begin
      act = 0; errm = 0; lastg = 1;
      l_addr = '0; l_wdata = '0;
      l_type = 0; l_size = '0;
      for (int n = 0; n < 2; n++) begin
        hold[n] = '0; known[n] = 1;
      end
    end else if (dn) begin
      act = 0;
      hold[own]  = val;
      known[own] = !(ok && l_type);
      if (ok) lastg = own;
      else errm = 1;
    end else if (!act && (|s_req)) begin
      act = 1; g = cyc_n;
      own = pick(s_req);
      l_addr  = s_addr[own];
      l_wdata = s_wdata[own];
      l_type  = s_type[own];
      l_size  = s_size[own];
    end
    cyc_n++;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic run_until(input int n);
    int k = 0;
    do begin cyc(); k++; end
    while (!m_done[n] && k < 40);
    if (!m_done[n]) begin
      checks++; failures++;
      $display("FAIL run_until port%0d: no completion in %0d cycles", n, k);
    end
  endtask

  task automatic set_port(input int n, input logic [31:0] a,
                          input logic [31:0] d, input logic t,
                          input logic [1:0] s);
    s_req[n]   = 1'b1;
    s_addr[n]  = a;
    s_wdata[n] = d;
    s_type[n]  = t;
    s_size[n]  = s;
  endtask

  task automatic new_fields(input int n);
    set_port(n, $urandom, $urandom, 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 2)));
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [31:0] act_v,
                     input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk("mem_req",   me.cyc, 32'(mem_req),   32'(me.mreq));
      chk("mem_addr",  me.cyc, mem_addr,       me.addr);
      chk("mem_wdata", me.cyc, mem_wdata,      me.wdata);
      chk("mem_type",  me.cyc, 32'(mem_type),  32'(me.typ));
      chk("mem_size",  me.cyc, 32'(mem_size),  32'(me.size));
      chk("rq_wait",   me.cyc, 32'(rq_wait),   32'(me.wt));
      chk("err_timeout", me.cyc, 32'(err_timeout), 32'(me.err));
      if (me.kn0) chk("rq_rdata0", me.cyc, rq_rdata[0], me.rd0);
      if (me.kn1) chk("rq_rdata1", me.cyc, rq_rdata[1], me.rd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rq_req = '0; rq_addr = '0;
    rq_wdata = '0; rq_type = '0; rq_size = '0;
    mem_rdata = '0; mem_wait = 1'b0;
    s_rst = 1'b1; s_req = '0;
    for (int n = 0; n < 2; n++) begin
      s_addr[n] = '0; s_wdata[n] = '0;
      s_type[n] = 0;  s_size[n]  = '0;
      hold[n] = '0; known[n] = 1; m_done[n] = 0;
    end
    cycles(3);
    s_rst = 1'b0;

    // single read, zero-latency memory
    force_k = 0;
    set_port(0, 32'h100, 32'h0, 1'b0, 2'd2);
    run_until(0);
    s_req[0] = 1'b0;
    cycles(2);

    // contention, both keep requesting
    set_port(0, 32'h200, 32'h1, 1'b0, 2'd2);
    set_port(1, 32'h300, 32'h2, 1'b0, 2'd1);
    for (int i = 0; i < 15; i++) begin
      for (int n = 0; n < 2; n++)
        if (m_done[n]) set_port(n, 32'h400 + 32'(i * 8 + n),
                                32'h0, 1'b0, 2'd2);
      cyc();
    end
    s_req = '0;
    cycles(4);

    // latched fields hold while the requester changes inputs
    force_k = 3;
    set_port(1, 32'h40, 32'hCAFE_F00D, 1'b1, 2'd2);
    cycles(3);
    s_addr[1] = 32'h1234;
    s_size[1] = 2'd0;
    run_until(1);
    s_req[1] = 1'b0;
    cycles(2);

    // hung memory
    force_k = 9;
    set_port(0, 32'h80, 32'h0, 1'b0, 2'd2);
    run_until(0);
    s_req[0] = 1'b0;
    cycles(4);
    force_k = 1;
    set_port(1, 32'h90, 32'h0, 1'b0, 2'd0);
    run_until(1);
    s_req[1] = 1'b0;
    cycles(2);

    // reset in the middle of WAIT
    force_k = 5;
    set_port(0, 32'hA0, 32'h0, 1'b0, 2'd2);
    cycles(4);
    s_rst = 1'b1;
    cyc();
    s_rst = 1'b0;
    force_k = 0;
    run_until(0);
    s_req[0] = 1'b0;
    cycles(2);

    // requester drops during WAIT
    force_k = 2;
    set_port(1, 32'hB0, 32'h0, 1'b0, 2'd2);
    cycles(3);
    s_req[1] = 1'b0;
    set_port(0, 32'hC0, 32'h0, 1'b0, 2'd2);
    run_until(1);
    run_until(0);
    s_req[0] = 1'b0;
    cycles(2);

    // randomized traffic
    force_k = -1;
    for (int i = 0; i < 2500; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (s_req[n]) begin
          if (m_done[n]) begin
            if ($urandom_range(0, 1) == 0) s_req[n] = 1'b0;
            else new_fields(n);
          end else if ($urandom_range(0, 31) == 0) begin
            s_req[n] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            new_fields(n);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          new_fields(n);
        end
      end
      s_rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    s_rst = 1'b0;
    s_req = '0;
    cycles(12);

    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
